axil_sample_fifo: RTL

- PL-side capture buffer directly upstream of the Zynq PS7 block design in the MQTT demo.
- Accepts 32-bit sensor samples on an AXI-Stream-style input and stores them in a FIFO.
- Exposes the FIFO to the PS over an AXI4-Lite slave (via the PS M_AXI_GP0 port), so PS software can drain samples and publish them as MQTT messages.
- Raises a level-threshold interrupt to the PS (IRQ_F2P).

---
 rtl/axil_sample_fifo_pkg.sv | 59 +++++
 rtl/axil_sample_fifo_fifo.sv | 79 +++++++
 rtl/axil_sample_fifo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_sample_fifo_pkg.sv
// Shared constants and types for the AXI4-Lite sample capture FIFO.
package axil_sample_fifo_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    // Register word index (byte address bits [3:2])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    // STATUS bit positions
    localparam int unsigned STAT_EMPTY = 16;
    localparam int unsigned STAT_FULL  = 17;
    localparam int unsigned STAT_OVF   = 18;

    // CTRL bit positions
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_FLUSH = 1;
    localparam int unsigned CTRL_IRQEN = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACCEPT,
        WR_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACCEPT,
        RD_DATA
    } rd_state_e;

    // Stored CTRL fields; flush is a write-only pulse and is not kept
    typedef struct packed {
        logic irq_en;
        logic enable;
    } ctrl_t;

    // Merge write data into the current register value under byte strobes
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wdata,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_sample_fifo_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module sync_fifo_fwft #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head_data_c,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full_c,
    output logic                  empty_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  push_ok_c;
    logic                  pop_ok_c;

    assign full_c      = (level_q == LVL_W'(DEPTH));
    assign empty_c     = (level_q == '0);
    assign head_data_c = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign push_ok_c   = push && !full_c;
    assign pop_ok_c    = pop && !empty_c;

    // Pointer and level update; flush overrides any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push_ok_c && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/axil_sample_fifo.sv
// Sample capture FIFO drained by the PS over an AXI4-Lite slave, with level IRQ.
module axil_sample_fifo
    import axil_sample_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [STRB_W-1:0]     s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  irq
);

    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic              awready_q, awready_d;
    logic              bvalid_q, bvalid_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [LVL_W-1:0]  thresh_q, thresh_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;

    logic              wr_en_c;
    logic              rd_en_c;
    logic              wr_hit_c;
    logic              rd_hit_c;
    logic [1:0]        wr_idx_c;
    logic [1:0]        rd_idx_c;
    logic [DATA_W-1:0] ctrl_word_c;
    logic [DATA_W-1:0] wr_cur_c;
    logic [DATA_W-1:0] wr_merged_c;
    logic [DATA_W-1:0] rd_value_c;
    logic              flush_c;
    logic              push_c;
    logic              pop_c;
    logic              unused_c;

    logic [DATA_W-1:0] fifo_head_c;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full_c;
    logic              fifo_empty_c;

    // Address decode: bits [3:2] pick the register, anything above must be zero
    assign wr_idx_c = s_axi_awaddr[3:2];
    assign rd_idx_c = s_axi_araddr[3:2];
    assign wr_hit_c = ((s_axi_awaddr >> 4) == '0);
    assign rd_hit_c = ((s_axi_araddr >> 4) == '0);

    assign s_tready      = ctrl_q.enable && !fifo_full_c;
    assign push_c        = s_tvalid && s_tready;
    assign pop_c         = rd_en_c && rd_hit_c && (rd_idx_c == REG_DATA) && !fifo_empty_c;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign irq           = irq_q;
    assign unused_c      = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], wr_merged_c};

    sync_fifo_fwft #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_W)
    ) u_fifo (
        .clk         (aclk),
        .rst_n       (aresetn),
        .push        (push_c),
        .push_data   (s_tdata),
        .pop         (pop_c),
        .flush       (flush_c),
        .head_data_c (fifo_head_c),
        .level       (fifo_level),
        .full_c      (fifo_full_c),
        .empty_c     (fifo_empty_c)
    );

    // Write channel FSM: pulse awready/wready, then hold bvalid until bready
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = 1'b0;
        bvalid_d   = bvalid_q;
        wr_en_c    = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    awready_d  = 1'b1;
                    wr_state_d = WR_ACCEPT;
                end
            end
            WR_ACCEPT: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    wr_en_c    = 1'b1;
                    bvalid_d   = 1'b1;
                    wr_state_d = WR_RESP;
                end else begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read channel FSM: pulse arready, register rdata, hold rvalid until rready
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rd_en_c    = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axi_arvalid) begin
                    arready_d  = 1'b1;
                    rd_state_d = RD_ACCEPT;
                end
            end
            RD_ACCEPT: begin
                if (s_axi_arvalid) begin
                    rd_en_c    = 1'b1;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_value_c;
                    rd_state_d = RD_DATA;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read data mux; an empty DATA read returns zero
    always_comb begin
        rd_value_c = '0;
        if (rd_hit_c) begin
            case (rd_idx_c)
                REG_DATA: begin
                    rd_value_c = fifo_empty_c ? '0 : fifo_head_c;
                end
                REG_STATUS: begin
                    rd_value_c[LVL_W-1:0]  = fifo_level;
                    rd_value_c[STAT_EMPTY] = fifo_empty_c;
                    rd_value_c[STAT_FULL]  = fifo_full_c;
                    rd_value_c[STAT_OVF]   = ovf_q;
                end
                REG_CTRL:   rd_value_c = ctrl_word_c;
                REG_THRESH: rd_value_c = DATA_W'(thresh_q);
                default:    rd_value_c = '0;
            endcase
        end
    end

    // CTRL as seen on the bus; flush always reads back zero
    always_comb begin
        ctrl_word_c             = '0;
        ctrl_word_c[CTRL_EN]    = ctrl_q.enable;
        ctrl_word_c[CTRL_IRQEN] = ctrl_q.irq_en;
    end

    // Register writes, overflow tracking and interrupt level
    always_comb begin
        ctrl_d   = ctrl_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        flush_c  = 1'b0;
        case (wr_idx_c)
            REG_CTRL:   wr_cur_c = ctrl_word_c;
            REG_THRESH: wr_cur_c = DATA_W'(thresh_q);
            default:    wr_cur_c = '0;
        endcase
        wr_merged_c = apply_wstrb(wr_cur_c, s_axi_wdata, s_axi_wstrb);
        if (wr_en_c && wr_hit_c) begin
            case (wr_idx_c)
                REG_STATUS: begin
                    if (s_axi_wstrb[STAT_OVF/8] && s_axi_wdata[STAT_OVF]) begin
                        ovf_d = 1'b0;
                    end
                end
                REG_CTRL: begin
                    ctrl_d.enable = wr_merged_c[CTRL_EN];
                    ctrl_d.irq_en = wr_merged_c[CTRL_IRQEN];
                    flush_c       = wr_merged_c[CTRL_FLUSH];
                end
                REG_THRESH: begin
                    thresh_d = wr_merged_c[LVL_W-1:0];
                end
                default: ;
            endcase
        end
        // A new overflow wins over a simultaneous clear
        if (s_tvalid && ctrl_q.enable && fifo_full_c) begin
            ovf_d = 1'b1;
        end
        irq_d = ctrl_q.irq_en && (thresh_q != '0) && (fifo_level >= thresh_q);
    end

    // State and register flops
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            thresh_q   <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            thresh_q   <= thresh_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

endmodule
